program_loader: RTL and testbench

- Boot-time writer for the instruction memory. The CPU core only reads that memory; this block is the other end and fills it.
- Accepts a byte stream (UART receiver or testbench) carrying a length header plus little-endian 32-bit instruction words.
- Writes each assembled word to consecutive instruction-memory addresses starting at 0.
- Holds the microprocessor in reset (cpu_rst) until a load completes cleanly.

---
 rtl/program_loader.sv | 188 ++++++++++++++++++
 tb/tb_program_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Boot-time instruction-memory loader: length header + little-endian words, CPU held in reset until clean completion.
// Optional trailing XOR checksum byte enabled by defining PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int WORD_SIZE      = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter int BYTES_PER_WORD = WORD_SIZE / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_SIZE-1:0]  mem_wdata,
  output logic                  cpu_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int IDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_DONE,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    S_ERR,
    S_CHK
`else
    S_ERR
`endif
  } state_t;

  // State entered once every word has been written (or immediately for N=0).
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam state_t S_FINAL = S_CHK;
`else
  localparam state_t S_FINAL = S_DONE;
`endif

  state_t                r_state;
  state_t                w_state_nxt;
  logic [15:0]           r_len;
  logic [IDX_W-1:0]      r_idx;
  logic [WORD_SIZE-1:0]  r_word;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_words;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]            r_csum;
`endif

  logic                  w_accept;
  logic                  w_start_ok;
  logic                  w_last_word;
  logic                  w_last_byte;
  logic [15:0]           w_len_full;
  logic [ADDR_WIDTH:0]   w_words_inc;

  assign w_accept    = rx_valid && rx_ready;
  assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
  assign w_len_full  = {rx_data, r_len[7:0]};
  assign w_words_inc = r_words + 1'b1;
  assign w_last_word = (16'(w_words_inc) == r_len);
  assign w_last_byte = (r_idx == IDX_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    rx_ready    = 1'b0;
    mem_we      = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    error       = 1'b0;
    cpu_rst     = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_LEN_LO;
      end
      S_LEN_LO: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid) w_state_nxt = S_LEN_HI;
      end
      S_LEN_HI: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid) begin
          if (w_len_full == 16'd0) begin
            w_state_nxt = S_FINAL;
          end else if (w_len_full > 16'(DEPTH)) begin
            w_state_nxt = S_ERR;
          end else begin
            w_state_nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid && w_last_byte) w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        mem_we      = 1'b1;
        busy        = 1'b1;
        w_state_nxt = w_last_word ? S_FINAL : S_DATA;
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CHK: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid) w_state_nxt = (rx_data == r_csum) ? S_DONE : S_ERR;
      end
`endif
      S_DONE: begin
        done    = 1'b1;
        cpu_rst = 1'b0;
        if (start) w_state_nxt = S_LEN_LO;
      end
      S_ERR: begin
        error = 1'b1;
        if (start) w_state_nxt = S_LEN_LO;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: length capture, byte staging, address and word counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len   <= '0;
      r_idx   <= '0;
      r_word  <= '0;
      r_addr  <= '0;
      r_words <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      r_csum  <= '0;
`endif
    end else if (w_start_ok) begin
      r_len   <= '0;
      r_idx   <= '0;
      r_addr  <= '0;
      r_words <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      r_csum  <= '0;
`endif
    end else begin
      case (r_state)
        S_LEN_LO: if (w_accept) r_len[7:0] <= rx_data;
        S_LEN_HI: if (w_accept) r_len[15:8] <= rx_data;
        S_DATA: begin
          if (w_accept) begin
            r_word[8*r_idx +: 8] <= rx_data;
            r_idx                <= r_idx + 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            r_csum               <= r_csum ^ rx_data;
`endif
          end
        end
        S_WRITE: begin
          r_addr  <= r_addr + 1'b1;
          r_words <= w_words_inc;
          r_idx   <= '0;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr     = r_addr;
  assign mem_wdata    = r_word;
  assign words_loaded = r_words;

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader; expected writes and status come from a word-list model.
module tb_program_loader;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        error;
  logic [5:0]  words_loaded;

  program_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_rst      (cpu_rst),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] words[64];
  logic [4:0]  obs_addr[$];
  logic [31:0] obs_data[$];

  always @(negedge clk) begin
    if (!rst && mem_we) begin
      obs_addr.push_back(mem_addr);
      obs_data.push_back(mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int cnt;
    if (gaps) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    cnt      = 0;
    while (!rx_ready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    if (!rx_ready) check("rx_ready_timeout", 32'(rx_ready), 32'd1);
    else @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_done_clr", 32'(done), 32'd0);
    check("start_err_clr", 32'(error), 32'd0);
    check("start_cpu_rst", 32'(cpu_rst), 32'd1);
    check("start_words", 32'(words_loaded), 32'd0);
    check("start_addr", 32'(mem_addr), 32'd0);
    check("start_ready", 32'(rx_ready), 32'd1);
  endtask

  task automatic wait_idle();
    int cnt;
    cnt = 0;
    while (busy && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    if (busy) check("busy_timeout", 32'(busy), 32'd0);
  endtask

  // Full load of n words from words[]; bad_csum corrupts the trailing checksum when that feature exists.
  task automatic run_load(input int n, input bit gaps, input bit bad_csum, input bit poke_start);
    logic [7:0] csum;
    logic [7:0] b;
    bit         exp_ok;
    int         exp_writes;
    obs_addr.delete();
    obs_data.delete();
    csum = 8'h00;
    pulse_start();
    send_byte(8'(n), gaps);
    send_byte(8'(n >> 8), gaps);
    if (n <= DEPTH) begin
      for (int i = 0; i < n; i++) begin
        for (int k = 0; k < 4; k++) begin
          b    = words[i][8*k +: 8];
          csum = csum ^ b;
          send_byte(b, gaps);
          if (poke_start && i == 0 && k == 3) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
          end
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      send_byte(csum ^ {7'b0, bad_csum}, gaps);
`endif
    end
    wait_idle();
    exp_ok     = (n <= DEPTH) && !bad_csum;
    exp_writes = (n <= DEPTH) ? n : 0;
    check("end_done", 32'(done), 32'(exp_ok));
    check("end_error", 32'(error), 32'(!exp_ok));
    check("end_cpu_rst", 32'(cpu_rst), 32'(!exp_ok));
    check("end_ready", 32'(rx_ready), 32'd0);
    check("write_count", 32'(obs_addr.size()), 32'(exp_writes));
    for (int i = 0; i < exp_writes && i < obs_addr.size(); i++) begin
      check("write_addr", 32'(obs_addr[i]), 32'(i % DEPTH));
      check("write_data", obs_data[i], words[i]);
    end
    if (n <= DEPTH) begin
      check("end_words", 32'(words_loaded), 32'(n));
      check("end_addr", 32'(mem_addr), 32'(n % DEPTH));
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(rx_ready), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed two-word load.
    words[0] = 32'hDEADBEEF;
    words[1] = 32'h12345678;
    run_load(2, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a three-word load.
    for (int i = 0; i < 3; i++) words[i] = $urandom;
    obs_addr.delete();
    obs_data.delete();
    pulse_start();
    send_byte(8'd3, 1'b0);
    send_byte(8'd0, 1'b0);
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 4; k++) send_byte(words[i][8*k +: 8], 1'b0);
    @(negedge clk);
    check("midrst_writes", 32'(obs_addr.size()), 32'd2);
    #1 rst = 1'b1;
    #1;
    check("midrst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("midrst_we", 32'(mem_we), 32'd0);
    check("midrst_words", 32'(words_loaded), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(rx_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_load(3, 1'b0, 1'b0, 1'b0);

    // Oversized lengths abort before any write.
    run_load(33, 1'b0, 1'b0, 1'b0);
    run_load(256, 1'b1, 1'b0, 1'b0);

    // Full-depth load with random gaps and a start poke mid-load.
    for (int i = 0; i < DEPTH; i++) words[i] = $urandom;
    run_load(DEPTH, 1'b1, 1'b0, 1'b1);

    // Empty load.
    run_load(0, 1'b0, 1'b0, 1'b0);

    // Random short loads.
    for (int t = 0; t < 4; t++) begin
      int n;
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) words[i] = $urandom;
      run_load(n, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    words[0] = 32'h08040201;
    run_load(1, 1'b0, 1'b0, 1'b0);
    run_load(1, 1'b0, 1'b1, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
